// File: rtl/bldc_ol_commutator_if.sv
// Setpoint / gate bus between the speed-control registers (master) and the
// open-loop six-step commutator (slave).
interface bldc_ol_commutator_if #(
    parameter int CNT_W = 24
);
    logic             ena_i;
    logic             dir_i;
    logic             pwm_i;
    logic [CNT_W-1:0] start_period_i;
    logic [CNT_W-1:0] target_period_i;
    logic [CNT_W-1:0] ramp_step_i;
    logic [CNT_W-1:0] align_cycles_i;
    logic [5:0]       gate_o;
    logic [2:0]       phase_o;
    logic [1:0]       state_o;
    logic             step_o;
    logic             at_speed_o;

    modport master (
        output ena_i, dir_i, pwm_i, start_period_i, target_period_i, ramp_step_i, align_cycles_i,
        input  gate_o, phase_o, state_o, step_o, at_speed_o
    );

    modport slave (
        input  ena_i, dir_i, pwm_i, start_period_i, target_period_i, ramp_step_i, align_cycles_i,
        output gate_o, phase_o, state_o, step_o, at_speed_o
    );
endinterface

// File: rtl/bldc_ol_commutator.sv
// Open-loop six-step BLDC commutator: align/ramp/run sequencing, direction
// select, dead-time overlap masking and PWM gating of the high-side switches.
module bldc_ol_commutator #(
    parameter int CNT_W    = 24,
    parameter int DEAD_CYC = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    bldc_ol_commutator_if.slave bus
);
    localparam int               DEAD_W     = $clog2(DEAD_CYC + 1);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(DEAD_CYC + 2);
    localparam logic [5:0]       LOW_SIDE   = 6'b010101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RAMP  = 2'd2,
        RUN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic [5:0]        old_pat_q, old_pat_d;
    logic [5:0]        gate_q, gate_d;
    logic              step_q, step_d;
    logic              at_speed_q, at_speed_d;

    logic [CNT_W-1:0]  eff_period, align_len, ramp_next;
    logic [5:0]        cur_pat, base_pat;
    logic              last_count;

    // Each pattern has exactly one high-side and one low-side switch on, on different legs.
    function automatic logic [5:0] pattern(input logic [2:0] ph);
        case (ph)
            3'd1:    pattern = 6'b100100;
            3'd2:    pattern = 6'b100001;
            3'd3:    pattern = 6'b001001;
            3'd4:    pattern = 6'b011000;
            3'd5:    pattern = 6'b010010;
            3'd6:    pattern = 6'b000110;
            default: pattern = 6'b000000;
        endcase
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic dir);
        if (!dir) next_phase = (ph == 3'd6) ? 3'd1 : ph + 3'd1;
        else      next_phase = (ph == 3'd1) ? 3'd6 : ph - 3'd1;
    endfunction

    assign cur_pat    = pattern(phase_q);
    assign eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
    assign align_len  = (bus.align_cycles_i == '0) ? CNT_W'(1) : bus.align_cycles_i;
    assign last_count = (timer_q == eff_period - CNT_W'(1));

    // Compare before subtracting so a large ramp step can never wrap below target.
    assign ramp_next = (period_q > bus.target_period_i &&
                        (period_q - bus.target_period_i) > bus.ramp_step_i)
                       ? period_q - bus.ramp_step_i : bus.target_period_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        period_d = period_q;
        timer_d  = timer_q;
        step_d   = 1'b0;

        if (!bus.ena_i) begin
            state_d  = IDLE;
            phase_d  = 3'd0;
            period_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ALIGN;
                    phase_d = 3'd1;
                    dir_d   = bus.dir_i;
                    timer_d = align_len - CNT_W'(1);
                end
                ALIGN: begin
                    if (timer_q == '0) begin
                        phase_d = next_phase(phase_q, dir_q);
                        step_d  = 1'b1;
                        if (bus.start_period_i <= bus.target_period_i) begin
                            state_d  = RUN;
                            period_d = bus.target_period_i;
                        end else begin
                            state_d  = RAMP;
                            period_d = bus.start_period_i;
                        end
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                RAMP: begin
                    if (last_count) begin
                        phase_d  = next_phase(phase_q, dir_q);
                        step_d   = 1'b1;
                        timer_d  = '0;
                        period_d = ramp_next;
                        if (ramp_next == bus.target_period_i) state_d = RUN;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (last_count) begin
                        phase_d  = next_phase(phase_q, dir_q);
                        step_d   = 1'b1;
                        timer_d  = '0;
                        period_d = bus.target_period_i;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        at_speed_d = (state_d == RUN);

        // Any phase change (including from/to phase 0) starts a fresh overlap window.
        dead_d    = dead_q;
        old_pat_d = old_pat_q;
        if (phase_d != phase_q) begin
            dead_d    = DEAD_W'(DEAD_CYC);
            old_pat_d = cur_pat;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DEAD_W'(1);
        end

        if (state_q == IDLE)      base_pat = 6'b000000;
        else if (dead_q != '0)    base_pat = cur_pat & old_pat_q;
        else                      base_pat = cur_pat;
        gate_d = base_pat & (bus.pwm_i ? 6'b111111 : LOW_SIDE);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q    <= IDLE;
            phase_q    <= 3'd0;
            dir_q      <= 1'b0;
            period_q   <= '0;
            timer_q    <= '0;
            dead_q     <= '0;
            old_pat_q  <= 6'b000000;
            gate_q     <= 6'b000000;
            step_q     <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            period_q   <= period_d;
            timer_q    <= timer_d;
            dead_q     <= dead_d;
            old_pat_q  <= old_pat_d;
            gate_q     <= gate_d;
            step_q     <= step_d;
            at_speed_q <= at_speed_d;
        end
    end

    assign bus.gate_o     = gate_q;
    assign bus.phase_o    = phase_q;
    assign bus.state_o    = state_q;
    assign bus.step_o     = step_q;
    assign bus.at_speed_o = at_speed_q;
endmodule

// File: tb/tb_bldc_ol_commutator.sv
// Scoreboard bench for bldc_ol_commutator: scenarios push expected phase
// segments, a negedge monitor measures each segment and compares.
module tb_bldc_ol_commutator;
    localparam int CNT_W    = 24;
    localparam int DEAD_CYC = 8;

    typedef struct {
        logic [2:0] phase;
        int         len;       // 0: segment is cut short by the scenario, length not checked
        logic [1:0] state;
        logic       at_speed;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bldc_ol_commutator_if #(.CNT_W(CNT_W)) bus ();

    bldc_ol_commutator #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   n_checks    = 0;
    int   n_pass      = 0;
    int   seg_idx     = 0;
    int   stray_steps = 0;
    int   shoot_errs  = 0;
    seg_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] ph, input int len, input logic [1:0] st, input logic as);
        seg_t s;
        s.phase = ph; s.len = len; s.state = st; s.at_speed = as;
        exp_q.push_back(s);
    endtask

    task automatic cfg(input int align, input int start, input int target, input int step, input logic dir);
        bus.align_cycles_i  = CNT_W'(align);
        bus.start_period_i  = CNT_W'(start);
        bus.target_period_i = CNT_W'(target);
        bus.ramp_step_i     = CNT_W'(step);
        bus.dir_i           = dir;
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), n);
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
        int k = 0;
        while (bus.phase_o != p && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, bus.phase_o, p);
    endtask

    task automatic check_dead(input logic [5:0] overlap, input logic [5:0] fresh, input string tag);
        for (int k = 1; k <= DEAD_CYC; k++) begin
            @(negedge clk);
            check($sformatf("%s_dead%0d", tag, k), bus.gate_o, overlap);
        end
        @(negedge clk);
        check({tag, "_after_dead"}, bus.gate_o, fresh);
    endtask

    // Monitor: measures every non-zero phase segment and checks it against the queue.
    logic [2:0] cur_ph  = 3'd0;
    int         cur_len = 0;
    logic [1:0] cur_st  = 2'd0;
    logic       cur_as  = 1'b0;

    always @(negedge clk) begin
        seg_t e;
        if ((bus.gate_o[5] & bus.gate_o[4]) | (bus.gate_o[3] & bus.gate_o[2]) |
            (bus.gate_o[1] & bus.gate_o[0]))
            shoot_errs++;
        if (bus.phase_o != cur_ph) begin
            if (cur_ph != 3'd0) begin
                if (exp_q.size() == 0) begin
                    check("extra_segment_phase", cur_ph, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("seg%0d_phase", seg_idx), cur_ph, e.phase);
                    if (e.len != 0) check($sformatf("seg%0d_len", seg_idx), cur_len, e.len);
                    check($sformatf("seg%0d_state", seg_idx), cur_st, e.state);
                    check($sformatf("seg%0d_at_speed", seg_idx), cur_as, e.at_speed);
                end
                seg_idx++;
                if (bus.phase_o != 3'd0) check("step_on_change", bus.step_o, 1);
            end
            cur_ph  = bus.phase_o;
            cur_len = 1;
            cur_st  = bus.state_o;
            cur_as  = bus.at_speed_o;
        end else begin
            cur_len++;
            if (bus.step_o) stray_steps++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ena_i = 1'b1;
        bus.pwm_i = 1'b1;
        cfg(100, 1000, 400, 200, 1'b0);

        // Reset dominates a run request.
        repeat (10) begin
            @(negedge clk);
            check("reset_outputs_zero",
                  {bus.gate_o, bus.phase_o, bus.state_o, bus.step_o, bus.at_speed_o}, 0);
        end
        bus.ena_i = 1'b0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);

        // Align then ramp 1000 -> 800 -> 600 -> run at 400.
        cfg(100, 1000, 400, 200, 1'b0);
        push(3'd1, 100, 2'd1, 1'b0);
        push(3'd2, 1000, 2'd2, 1'b0);
        push(3'd3, 800, 2'd2, 1'b0);
        push(3'd4, 600, 2'd2, 1'b0);
        push(3'd5, 400, 2'd3, 1'b1);
        push(3'd6, 400, 2'd3, 1'b1);
        push(3'd1, 400, 2'd3, 1'b1);
        push(3'd2, 0, 2'd3, 1'b1);
        bus.ena_i = 1'b1;
        wait_q(1, 5000, "ramp_reaches_run");
        repeat (50) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "ramp_drain");
        repeat (5) @(negedge clk);

        // Reverse direction; dir_i toggled mid-run must be ignored.
        cfg(20, 100, 100, 0, 1'b1);
        push(3'd1, 20, 2'd1, 1'b0);
        push(3'd6, 100, 2'd3, 1'b1);
        push(3'd5, 100, 2'd3, 1'b1);
        push(3'd4, 100, 2'd3, 1'b1);
        push(3'd3, 100, 2'd3, 1'b1);
        push(3'd2, 100, 2'd3, 1'b1);
        push(3'd1, 100, 2'd3, 1'b1);
        push(3'd6, 0, 2'd3, 1'b1);
        bus.ena_i = 1'b1;
        wait_q(6, 200, "reverse_first_step");
        bus.dir_i = 1'b0;
        wait_q(1, 1000, "reverse_full_turn");
        repeat (20) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "reverse_drain");
        repeat (5) @(negedge clk);

        // Dead time, PWM gating and disable latency.
        cfg(30, 50, 50, 0, 1'b0);
        push(3'd1, 30, 2'd1, 1'b0);
        push(3'd2, 0, 2'd3, 1'b1);
        bus.ena_i = 1'b1;
        wait_phase(3'd1, 5, "align_entry_phase");
        check_dead(6'b000000, 6'b100100, "align_entry");
        wait_phase(3'd2, 40, "p1_to_p2_phase");
        check_dead(6'b100000, 6'b100001, "p1_to_p2");
        bus.pwm_i = 1'b0;
        @(negedge clk);
        check("pwm_low_gate", bus.gate_o, 6'b000001);
        bus.pwm_i = 1'b1;
        @(negedge clk);
        check("pwm_high_gate", bus.gate_o, 6'b100001);
        bus.ena_i = 1'b0;
        @(negedge clk);
        check("disable_state_phase_speed", {bus.state_o, bus.phase_o, bus.at_speed_o}, 0);
        check("disable_gate_still_on", bus.gate_o, 6'b100001);
        @(negedge clk);
        check("disable_gate_off", bus.gate_o, 6'b000000);
        wait_q(0, 10, "gate_drain");
        repeat (5) @(negedge clk);

        // Abort mid-ramp, then re-enable restarts from align and start period.
        cfg(40, 300, 100, 100, 1'b0);
        push(3'd1, 40, 2'd1, 1'b0);
        push(3'd2, 300, 2'd2, 1'b0);
        push(3'd3, 0, 2'd2, 1'b0);
        bus.ena_i = 1'b1;
        wait_q(1, 1000, "abort_reach_p3");
        repeat (50) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "abort_drain");
        repeat (3) @(negedge clk);
        push(3'd1, 40, 2'd1, 1'b0);
        push(3'd2, 300, 2'd2, 1'b0);
        push(3'd3, 200, 2'd2, 1'b0);
        push(3'd4, 100, 2'd3, 1'b1);
        push(3'd5, 0, 2'd3, 1'b1);
        bus.ena_i = 1'b1;
        wait_q(1, 2000, "restart_reach_run");
        repeat (20) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "restart_drain");
        repeat (5) @(negedge clk);

        // Zero align length and periods below the dead-time floor.
        cfg(0, 3, 3, 0, 1'b0);
        push(3'd1, 1, 2'd1, 1'b0);
        push(3'd2, DEAD_CYC + 2, 2'd3, 1'b1);
        push(3'd3, DEAD_CYC + 2, 2'd3, 1'b1);
        push(3'd4, DEAD_CYC + 2, 2'd3, 1'b1);
        push(3'd5, 0, 2'd3, 1'b1);
        bus.ena_i = 1'b1;
        wait_q(1, 200, "clamp_reach_p5");
        repeat (3) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "clamp_drain");
        repeat (5) @(negedge clk);

        // Zero ramp step holds RAMP at the start period.
        cfg(5, 60, 20, 0, 1'b0);
        push(3'd1, 5, 2'd1, 1'b0);
        push(3'd2, 60, 2'd2, 1'b0);
        push(3'd3, 60, 2'd2, 1'b0);
        push(3'd4, 60, 2'd2, 1'b0);
        push(3'd5, 0, 2'd2, 1'b0);
        bus.ena_i = 1'b1;
        wait_q(1, 500, "flat_ramp_reach_p5");
        repeat (10) @(negedge clk);
        bus.ena_i = 1'b0;
        wait_q(0, 10, "flat_ramp_drain");
        repeat (5) @(negedge clk);

        check("no_shoot_through", shoot_errs, 0);
        check("no_stray_step", stray_steps, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
